// File: rtl/sdram_streamer_pkg.sv
// Shared types and constants for the SDRAM write streamer: FSM states, default
// bus geometry, the buffered-word record and a pointer-width helper.
package sdram_streamer_pkg;

   localparam int DEF_DATAWIDTH    = 32;
   localparam int DEF_ADDRESSWIDTH = 32;
   localparam int DEF_FIFO_DEPTH   = 16;
   localparam int DEF_COUNTWIDTH   = 16;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      FLUSH,
      DONE
   } state_t;

   // One buffered producer word at the default bus geometry.
   typedef struct packed {
      logic [DEF_ADDRESSWIDTH-1:0]  address;
      logic [DEF_DATAWIDTH/8-1:0]   byteenable;
      logic [DEF_DATAWIDTH-1:0]     data;
   } fifo_entry_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head and a look-ahead at the entry
// behind it, so the consumer can present words back-to-back while popping.
module sync_fifo
   import sdram_streamer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [WIDTH-1:0] next_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign head_data = mem[rd_ptr_reg];
   assign next_data = mem[rd_ptr_reg + AW'(1)];

   // Storage has no reset; a reset only rewinds the pointers, discarding contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/sdram_write_streamer.sv
// Buffers producer writes in a FIFO and replays them onto an Avalon-MM master;
// raises a sticky irq once a finished frame has been fully accepted downstream.
module sdram_write_streamer
   import sdram_streamer_pkg::*;
#(
   parameter int DATAWIDTH       = DEF_DATAWIDTH,
   parameter int BYTEENABLEWIDTH = DATAWIDTH / 8,
   parameter int ADDRESSWIDTH    = DEF_ADDRESSWIDTH,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
   parameter int COUNTWIDTH      = DEF_COUNTWIDTH
)(
   input  logic                       clock50MHz,
   input  logic                       reset,
   input  logic                       auto_incr,
   input  logic [ADDRESSWIDTH-1:0]    base_address,
   input  logic                       load_base,
   input  logic [ADDRESSWIDTH-1:0]    sdram_address,
   input  logic [BYTEENABLEWIDTH-1:0] sdram_byteenable,
   input  logic                       sdram_write,
   input  logic [DATAWIDTH-1:0]       sdram_writedata,
   output logic                       sdram_waitrequest,
   input  logic                       sdram_finished,
   input  logic                       irq_ack,
   output logic [ADDRESSWIDTH-1:0]    master_address,
   output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
   output logic                       master_write,
   output logic [DATAWIDTH-1:0]       master_writedata,
   input  logic                       master_waitrequest,
   output logic                       irq,
   output logic [COUNTWIDTH-1:0]      word_count,
   output logic                       busy
);

   localparam int FIFO_AW = clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [ADDRESSWIDTH-1:0]    address;
      logic [BYTEENABLEWIDTH-1:0] byteenable;
      logic [DATAWIDTH-1:0]       data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   state_t                  state_reg, state_next;
   entry_t                  push_entry, head_entry, next_entry;
   entry_t                  master_reg, master_next;
   logic                    master_write_reg, master_write_next;
   logic [ADDRESSWIDTH-1:0] pointer_reg;
   logic [COUNTWIDTH-1:0]   word_count_reg;
   logic                    irq_reg;
   logic                    finish_pending_reg;
   logic                    fifo_full, fifo_empty;
   logic [FIFO_AW:0]        fifo_count;
   logic                    push, pop, set_irq;

   assign push = sdram_write && !fifo_full;

   // A load_base on the same edge as a write hands that write the new base.
   always_comb begin
      push_entry.address    = auto_incr ? (load_base ? base_address : pointer_reg)
                                        : sdram_address;
      push_entry.byteenable = sdram_byteenable;
      push_entry.data       = sdram_writedata;
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clock50MHz),
      .rst_n     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_entry),
      .next_data (next_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clock50MHz or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      master_next       = master_reg;
      master_write_next = master_write_reg;
      pop               = 1'b0;
      set_irq           = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (!fifo_empty) begin
               master_next       = head_entry;
               master_write_next = 1'b1;
               state_next        = WRITE;
            end else if (finish_pending_reg) begin
               state_next = FLUSH;
            end
         end
         WRITE: begin
            if (!master_waitrequest) begin
               pop = 1'b1;
               if (fifo_count > (FIFO_AW+1)'(1)) begin
                  master_next = next_entry;
               end else begin
                  // A word pushed on this edge keeps the frame open; IDLE picks it up.
                  master_write_next = 1'b0;
                  if ((finish_pending_reg || sdram_finished) && !push) begin
                     state_next = FLUSH;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         FLUSH: begin
            set_irq    = 1'b1;
            state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock50MHz or negedge reset) begin
      if (!reset) begin
         master_reg         <= '0;
         master_write_reg   <= 1'b0;
         pointer_reg        <= '0;
         word_count_reg     <= '0;
         irq_reg            <= 1'b0;
         finish_pending_reg <= 1'b0;
      end else begin
         master_reg       <= master_next;
         master_write_reg <= master_write_next;
         if (load_base) begin
            pointer_reg <= base_address;
         end else if (push && auto_incr) begin
            pointer_reg <= pointer_reg + ADDRESSWIDTH'(BYTEENABLEWIDTH);
         end
         if (load_base) begin
            word_count_reg <= '0;
         end else if (pop) begin
            word_count_reg <= word_count_reg + COUNTWIDTH'(1);
         end
         if (set_irq) begin
            irq_reg <= 1'b1;
         end else if (irq_ack) begin
            irq_reg <= 1'b0;
         end
         // Finishes seen while the flush completes fold into the same irq.
         if (set_irq) begin
            finish_pending_reg <= 1'b0;
         end else if (sdram_finished) begin
            finish_pending_reg <= 1'b1;
         end
      end
   end

   assign sdram_waitrequest = fifo_full;
   assign master_address    = master_reg.address;
   assign master_byteenable = master_reg.byteenable;
   assign master_writedata  = master_reg.data;
   assign master_write      = master_write_reg;
   assign irq               = irq_reg;
   assign word_count        = word_count_reg;
   assign busy              = !fifo_empty || master_write_reg;

endmodule

// File: tb/tb_sdram_write_streamer.sv
// Directed bench for sdram_write_streamer: a cycle table for streaming and stall
// behaviour, then hand-written sequences for full FIFO, irq, wrap and reset.
module tb_sdram_write_streamer;
   import sdram_streamer_pkg::*;

   logic        clock50MHz;
   logic        reset;
   logic        auto_incr;
   logic [31:0] base_address;
   logic        load_base;
   logic [31:0] sdram_address;
   logic [3:0]  sdram_byteenable;
   logic        sdram_write;
   logic [31:0] sdram_writedata;
   logic        sdram_waitrequest;
   logic        sdram_finished;
   logic        irq_ack;
   logic [31:0] master_address;
   logic [3:0]  master_byteenable;
   logic        master_write;
   logic [31:0] master_writedata;
   logic        master_waitrequest;
   logic        irq;
   logic [15:0] word_count;
   logic        busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [31:0] acc_addr[$];
   logic [31:0] acc_data[$];

   typedef struct {
      logic        lb;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] data;
      logic        mwait;
      logic        exp_mw;
      fifo_entry_t exp;
      logic [15:0] exp_wc;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[15];

   sdram_write_streamer dut (
      .clock50MHz         (clock50MHz),
      .reset              (reset),
      .auto_incr          (auto_incr),
      .base_address       (base_address),
      .load_base          (load_base),
      .sdram_address      (sdram_address),
      .sdram_byteenable   (sdram_byteenable),
      .sdram_write        (sdram_write),
      .sdram_writedata    (sdram_writedata),
      .sdram_waitrequest  (sdram_waitrequest),
      .sdram_finished     (sdram_finished),
      .irq_ack            (irq_ack),
      .master_address     (master_address),
      .master_byteenable  (master_byteenable),
      .master_write       (master_write),
      .master_writedata   (master_writedata),
      .master_waitrequest (master_waitrequest),
      .irq                (irq),
      .word_count         (word_count),
      .busy               (busy)
   );

   initial begin
      clock50MHz = 1'b0;
      forever #10 clock50MHz = ~clock50MHz;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Record every Avalon accept, sampled mid-cycle.
   always @(negedge clock50MHz) begin
      if (reset && master_write && !master_waitrequest) begin
         acc_addr.push_back(master_address);
         acc_data.push_back(master_writedata);
         $display("accept addr=%h data=%h be=%h", master_address, master_writedata, master_byteenable);
      end
   end

   task automatic tick();
      @(posedge clock50MHz);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check({name, "_drain"}, 64'(busy), 64'd0);
   endtask

   function automatic vec_t mk(input logic lb, input logic wr, input logic [3:0] be,
                               input logic [31:0] data, input logic mwait,
                               input logic exp_mw, input logic [31:0] ea,
                               input logic [31:0] ed, input logic [3:0] ebe,
                               input logic [15:0] ewc, input logic ebusy);
      vec_t v;
      v.lb = lb; v.wr = wr; v.be = be; v.data = data; v.mwait = mwait;
      v.exp_mw = exp_mw;
      v.exp.address = ea; v.exp.data = ed; v.exp.byteenable = ebe;
      v.exp_wc = ewc; v.exp_busy = ebusy;
      return v;
   endfunction

   initial begin
      reset = 1'b0;
      auto_incr = 1'b0;
      base_address = '0;
      load_base = 1'b0;
      sdram_address = '0;
      sdram_byteenable = '0;
      sdram_write = 1'b0;
      sdram_writedata = '0;
      sdram_finished = 1'b0;
      irq_ack = 1'b0;
      master_waitrequest = 1'b0;

      // Streaming with base 0x1000, then a 5-cycle stall on 0xCAFEBABE.
      vecs[0]  = mk(1, 0, 4'h0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 16'd0, 0);
      vecs[1]  = mk(0, 1, 4'hF, 32'hA0000000, 0, 0, 32'h0,    32'h0,        4'h0, 16'd0, 1);
      vecs[2]  = mk(0, 1, 4'h3, 32'hA1111111, 0, 1, 32'h1000, 32'hA0000000, 4'hF, 16'd0, 1);
      vecs[3]  = mk(0, 1, 4'hC, 32'hA2222222, 0, 1, 32'h1004, 32'hA1111111, 4'h3, 16'd1, 1);
      vecs[4]  = mk(0, 0, 4'h0, 32'h0,        0, 1, 32'h1008, 32'hA2222222, 4'hC, 16'd2, 1);
      vecs[5]  = mk(0, 0, 4'h0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 16'd3, 0);
      vecs[6]  = mk(0, 1, 4'h5, 32'hCAFEBABE, 1, 0, 32'h0,    32'h0,        4'h0, 16'd3, 1);
      for (int i = 7; i <= 12; i++) begin
         vecs[i] = mk(0, 0, 4'h0, 32'h0, 1, 1, 32'h100C, 32'hCAFEBABE, 4'h5, 16'd3, 1);
      end
      vecs[13] = mk(0, 0, 4'h0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 16'd4, 0);
      vecs[14] = mk(0, 0, 4'h0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 16'd4, 0);

      tick();
      tick();
      check("rst_master_write", 64'(master_write), 64'd0);
      check("rst_master_address", 64'(master_address), 64'd0);
      check("rst_master_data", 64'(master_writedata), 64'd0);
      check("rst_master_be", 64'(master_byteenable), 64'd0);
      check("rst_irq", 64'(irq), 64'd0);
      check("rst_word_count", 64'(word_count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_waitrequest", 64'(sdram_waitrequest), 64'd0);

      reset = 1'b1;
      tick();

      // Table-driven streaming
      auto_incr = 1'b1;
      base_address = 32'h1000;
      sdram_address = 32'hDEAD0000;
      for (int i = 0; i < 15; i++) begin
         load_base = vecs[i].lb;
         sdram_write = vecs[i].wr;
         sdram_byteenable = vecs[i].be;
         sdram_writedata = vecs[i].data;
         master_waitrequest = vecs[i].mwait;
         tick();
         $display("vec %0d: mw=%0b addr=%h data=%h be=%h wc=%0d busy=%0b",
                  i, master_write, master_address, master_writedata, master_byteenable, word_count, busy);
         check($sformatf("vec%0d_mw", i), 64'(master_write), 64'(vecs[i].exp_mw));
         if (vecs[i].exp_mw) begin
            check($sformatf("vec%0d_addr", i), 64'(master_address), 64'(vecs[i].exp.address));
            check($sformatf("vec%0d_data", i), 64'(master_writedata), 64'(vecs[i].exp.data));
            check($sformatf("vec%0d_be", i), 64'(master_byteenable), 64'(vecs[i].exp.byteenable));
         end
         check($sformatf("vec%0d_wc", i), 64'(word_count), 64'(vecs[i].exp_wc));
         check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
         check($sformatf("vec%0d_swait", i), 64'(sdram_waitrequest), 64'd0);
      end
      load_base = 1'b0;
      sdram_write = 1'b0;
      master_waitrequest = 1'b0;

      // Fill the FIFO with the master stalled, then a 17th word
      acc_addr.delete();
      acc_data.delete();
      auto_incr = 1'b0;
      master_waitrequest = 1'b1;
      sdram_byteenable = 4'hF;
      for (int i = 0; i < 16; i++) begin
         sdram_write = 1'b1;
         sdram_address = 32'h4000 + 32'(i) * 4;
         sdram_writedata = 32'hF0000000 + 32'(i);
         tick();
         check($sformatf("fill%0d_swait", i), 64'(sdram_waitrequest), 64'(i == 15));
      end
      sdram_address = 32'h4040;
      sdram_writedata = 32'hF0000010;
      tick();
      tick();
      check("full_hold_swait", 64'(sdram_waitrequest), 64'd1);
      check("full_hold_wc", 64'(word_count), 64'd4);
      master_waitrequest = 1'b0;
      tick();
      check("first_pop_swait", 64'(sdram_waitrequest), 64'd0);
      check("first_pop_wc", 64'(word_count), 64'd5);
      tick();
      sdram_write = 1'b0;
      wait_idle("full");
      check("full_accepts", 64'(acc_data.size()), 64'd17);
      for (int i = 0; i < 17; i++) begin
         check($sformatf("full_data%0d", i), 64'(acc_data[i]), 64'(32'hF0000000 + 32'(i)));
         check($sformatf("full_addr%0d", i), 64'(acc_addr[i]), 64'(32'h4000 + 32'(i) * 4));
      end
      check("full_wc", 64'(word_count), 64'd21);

      // Finish on the edge of the last write; irq only after the 4th accept
      acc_addr.delete();
      acc_data.delete();
      master_waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sdram_write = 1'b1;
         sdram_address = 32'h8000 + 32'(i) * 4;
         sdram_writedata = 32'hB0 + 32'(i);
         sdram_finished = (i == 3);
         tick();
      end
      sdram_write = 1'b0;
      sdram_finished = 1'b0;
      tick();
      tick();
      check("irq_low_stalled", 64'(irq), 64'd0);
      master_waitrequest = 1'b0;
      for (int n = 0; n < 50 && !irq; n++) begin
         tick();
      end
      check("irq_rise", 64'(irq), 64'd1);
      check("irq_after_4_accepts", 64'(acc_data.size()), 64'd4);
      check("irq_last_data", 64'(acc_data[3]), 64'h0B3);
      check("irq_busy", 64'(busy), 64'd0);
      check("irq_wc", 64'(word_count), 64'd25);

      sdram_finished = 1'b1;
      tick();
      sdram_finished = 1'b0;
      for (int n = 0; n < 4; n++) tick();
      check("irq_second_finish", 64'(irq), 64'd1);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("irq_ack_clears", 64'(irq), 64'd0);
      for (int n = 0; n < 5; n++) tick();
      check("irq_no_extra_pulse", 64'(irq), 64'd0);
      check("irq_no_extra_accepts", 64'(acc_data.size()), 64'd4);

      // Pointer wrap and load_base concurrent with a write
      acc_addr.delete();
      acc_data.delete();
      auto_incr = 1'b1;
      base_address = 32'hFFFFFFFC;
      load_base = 1'b1;
      tick();
      load_base = 1'b0;
      check("wrap_load_wc", 64'(word_count), 64'd0);
      for (int i = 0; i < 2; i++) begin
         sdram_write = 1'b1;
         sdram_writedata = 32'hC0 + 32'(i);
         tick();
      end
      sdram_write = 1'b0;
      wait_idle("wrap");
      check("wrap_addr0", 64'(acc_addr[0]), 64'hFFFFFFFC);
      check("wrap_addr1", 64'(acc_addr[1]), 64'h00000000);
      check("wrap_wc", 64'(word_count), 64'd2);
      base_address = 32'h2000;
      load_base = 1'b1;
      sdram_write = 1'b1;
      sdram_writedata = 32'h5A5A5A5A;
      tick();
      load_base = 1'b0;
      sdram_write = 1'b0;
      check("lb_write_wc_cleared", 64'(word_count), 64'd0);
      wait_idle("lb");
      check("lb_write_addr", 64'(acc_addr[2]), 64'h2000);
      check("lb_write_data", 64'(acc_data[2]), 64'h5A5A5A5A);
      check("lb_write_wc", 64'(word_count), 64'd1);

      // irq_ack on the edge that sets irq: the set wins
      sdram_finished = 1'b1;
      tick();
      sdram_finished = 1'b0;
      irq_ack = 1'b1;
      tick();
      tick();
      irq_ack = 1'b0;
      check("ack_collision_irq", 64'(irq), 64'd1);
      tick();
      check("ack_collision_hold", 64'(irq), 64'd1);

      // Reset with three words buffered and the master stalled
      auto_incr = 1'b0;
      master_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sdram_write = 1'b1;
         sdram_address = 32'h9000 + 32'(i) * 4;
         sdram_writedata = 32'hD0 + 32'(i);
         tick();
      end
      sdram_write = 1'b0;
      check("pre_reset_mw", 64'(master_write), 64'd1);
      check("pre_reset_irq", 64'(irq), 64'd1);
      reset = 1'b0;
      acc_addr.delete();
      acc_data.delete();
      #2;
      check("reset_mw_async", 64'(master_write), 64'd0);
      check("reset_busy_async", 64'(busy), 64'd0);
      check("reset_irq_async", 64'(irq), 64'd0);
      tick();
      tick();
      reset = 1'b1;
      master_waitrequest = 1'b0;
      for (int n = 0; n < 3; n++) tick();
      check("post_reset_mw", 64'(master_write), 64'd0);
      check("post_reset_busy", 64'(busy), 64'd0);
      check("post_reset_irq", 64'(irq), 64'd0);
      check("post_reset_wc", 64'(word_count), 64'd0);
      check("post_reset_swait", 64'(sdram_waitrequest), 64'd0);
      check("post_reset_no_accepts", 64'(acc_data.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
